// File: rtl/alu_shift_pkg.sv
// Shared encodings for the sequential shifter: shift modes and FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_shift_pkg;

  // Shift mode encodings as seen on the mode port
  typedef enum logic [1:0] {
    LOGIC  = 2'b00,
    ARITH  = 2'b01,
    ROTATE = 2'b10,
    RSVD   = 2'b11
  } shift_mode_e;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// Single 1-bit shift of a word (logical / arithmetic / optional rotate), purely combinational.
// Latency: 0 cycles.
// Backpressure: none; SHIFT_SEQ_ROTATE_EN enables rotate feedback for mode ROTATE, otherwise it shifts logically.
module shift_step
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] word_i,
  input  logic             right_i,
  input  shift_mode_e      mode_i,
  output logic [WIDTH-1:0] word_o,
  output logic             out_bit_o
);

  logic fill;

  // Pick the bit leaving the word and the bit entering the vacated end
  always_comb begin
    fill      = 1'b0;
    word_o    = word_i;
    out_bit_o = 1'b0;
    if (right_i) begin
      out_bit_o = word_i[0];
      if (mode_i == ARITH) begin
        fill = word_i[WIDTH-1];
      end
`ifdef SHIFT_SEQ_ROTATE_EN
      else if (mode_i == ROTATE) begin
        fill = word_i[0];
      end
`endif
      word_o = {fill, word_i[WIDTH-1:1]};
    end else begin
      out_bit_o = word_i[WIDTH-1];
`ifdef SHIFT_SEQ_ROTATE_EN
      if (mode_i == ROTATE) begin
        fill = word_i[WIDTH-1];
      end
`endif
      word_o = {word_i[WIDTH-2:0], fill};
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequential shifter: shifts a captured operand one bit per cycle under an IDLE/SHIFT/DONE FSM.
// Latency: amount+1 cycles from the accepted start edge to the done pulse (1 cycle for amount=0).
// Backpressure: start is ignored while busy; results hold until the next accepted start. Macro: SHIFT_SEQ_ROTATE_EN.
module shift_seq_ctrl
  import alu_shift_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] operand,
  input  logic [CNT_W-1:0] amount,
  input  logic             right,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero
);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic             carry_q, carry_d;
  logic             right_q, right_d;
  shift_mode_e      mode_q, mode_d;

  logic [WIDTH-1:0] step_word;
  logic             step_bit;
  logic             accept;

  // A new request is taken whenever the sequencer is not mid-shift
  assign accept = start && (state_q != SHIFT);

  shift_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .word_i    (work_q),
    .right_i   (right_q),
    .mode_i    (mode_q),
    .word_o    (step_word),
    .out_bit_o (step_bit)
  );

  // State and datapath registers; reset clears everything immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      carry_q <= 1'b0;
      right_q <= 1'b0;
      mode_q  <= LOGIC;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      carry_q <= carry_d;
      right_q <= right_d;
      mode_q  <= mode_d;
    end
  end

  // Next FSM state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = (amount != '0) ? SHIFT : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture on accept, otherwise step the working register while shifting
  always_comb begin
    cnt_d   = cnt_q;
    work_d  = work_q;
    carry_d = carry_q;
    right_d = right_q;
    mode_d  = mode_q;
    if (accept) begin
      cnt_d   = amount;
      work_d  = operand;
      carry_d = 1'b0;
      right_d = right;
      mode_d  = shift_mode_e'(mode);
    end else if (state_q == SHIFT) begin
      cnt_d   = cnt_q - CNT_W'(1);
      work_d  = step_word;
      carry_d = step_bit;
    end
  end

  // Moore outputs; zero follows result combinationally
  always_comb begin
    busy   = (state_q == SHIFT);
    done   = (state_q == DONE);
    result = work_q;
    carry  = carry_q;
    zero   = ~|work_q;
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed self-checking bench for shift_seq_ctrl.
// Latency: n/a.
// Backpressure: n/a.
module tb_shift_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] operand;
  logic [3:0]  amount;
  logic        right;
  logic [1:0]  mode;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        carry;
  logic        zero;

  int n_cmp = 0;
  int n_err = 0;

  shift_seq_ctrl #(
    .WIDTH (16),
    .CNT_W (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .operand (operand),
    .amount  (amount),
    .right   (right),
    .mode    (mode),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .carry   (carry),
    .zero    (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one request from a point just after a rising edge and follow it to done
  task automatic run_op(input string tag, input logic [15:0] op, input logic [3:0] amt,
                        input logic r, input logic [1:0] m,
                        input logic [15:0] exp_res, input logic exp_c);
    int cyc;
    logic saw_busy;
    operand = op;
    amount  = amt;
    right   = r;
    mode    = m;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc      = 1;
    saw_busy = busy;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
      if (busy) saw_busy = 1'b1;
    end
    check({tag, "_latency"}, cyc, int'(amt) + 1);
    check({tag, "_result"}, {16'h0, result}, {16'h0, exp_res});
    check({tag, "_carry"}, {31'h0, carry}, {31'h0, exp_c});
    check({tag, "_zero"}, {31'h0, zero}, {31'h0, (exp_res == 16'h0)});
    check({tag, "_busy_at_done"}, {31'h0, busy}, 32'h0);
    if (amt == 4'd0) check({tag, "_busy_never"}, {31'h0, saw_busy}, 32'h0);
  endtask

  initial begin
    int cyc;
    logic saw_done;
    rst_n   = 1'b0;
    start   = 1'b0;
    operand = '0;
    amount  = '0;
    right   = 1'b0;
    mode    = 2'b00;

    // Reset state
    #12;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_result", {16'h0, result}, 32'h0);
    check("rst_carry", {31'h0, carry}, 32'h0);
    check("rst_zero", {31'h0, zero}, 32'h1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic function
    run_op("lsr1", 16'h8001, 4'd1, 1'b1, 2'b00, 16'h4000, 1'b1);
    run_op("asr4", 16'h8000, 4'd4, 1'b1, 2'b01, 16'hF800, 1'b0);
    run_op("amt0", 16'h00F0, 4'd0, 1'b0, 2'b00, 16'h00F0, 1'b0);
    run_op("rsvd_r2", 16'h8000, 4'd2, 1'b1, 2'b11, 16'h2000, 1'b0);
    run_op("asl1", 16'hC001, 4'd1, 1'b0, 2'b01, 16'h8002, 1'b1);

    // Full-range left shift, then back-to-back start from the DONE cycle
    run_op("lsl15", 16'h0001, 4'd15, 1'b0, 2'b00, 16'h8000, 1'b0);
    run_op("lsl1_b2b", 16'h8000, 4'd1, 1'b0, 2'b00, 16'h0000, 1'b1);

    // Result holds after done with no new start
    repeat (2) @(posedge clk);
    #1;
    check("hold_result", {16'h0, result}, 32'h0);
    check("hold_carry", {31'h0, carry}, 32'h1);
    check("hold_done", {31'h0, done}, 32'h0);

    // Start while busy is ignored
    operand = 16'h12B4;
    amount  = 4'd8;
    right   = 1'b1;
    mode    = 2'b00;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 1;
    @(posedge clk);
    #1 cyc++;
    check("ign_busy", {31'h0, busy}, 32'h1);
    operand = 16'hFFFF;
    amount  = 4'd1;
    right   = 1'b0;
    mode    = 2'b01;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc++;
    while (!done && cyc < 40) begin
      @(posedge clk);
      #1 cyc++;
    end
    check("ign_latency", cyc, 9);
    check("ign_result", {16'h0, result}, 32'h0012);
    check("ign_carry", {31'h0, carry}, 32'h1);
    @(posedge clk);
    #1;
    check("ign_no_restart", {31'h0, busy}, 32'h0);

    // Reset mid-shift
    operand = 16'hFFFF;
    amount  = 4'd8;
    right   = 1'b0;
    mode    = 2'b00;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_busy", {31'h0, busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy}, 32'h0);
    check("mid_rst_done", {31'h0, done}, 32'h0);
    check("mid_rst_result", {16'h0, result}, 32'h0);
    check("mid_rst_carry", {31'h0, carry}, 32'h0);
    check("mid_rst_zero", {31'h0, zero}, 32'h1);
    saw_done = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1 if (done) saw_done = 1'b1;
    end
    check("post_rst_no_done", {31'h0, saw_done}, 32'h0);
    check("post_rst_idle", {31'h0, busy}, 32'h0);
    check("post_rst_result", {16'h0, result}, 32'h0);

`ifdef SHIFT_SEQ_ROTATE_EN
    run_op("ror1", 16'h8001, 4'd1, 1'b1, 2'b10, 16'hC000, 1'b1);
    run_op("rol3", 16'hA001, 4'd3, 1'b0, 2'b10, 16'h000D, 1'b1);
`else
    run_op("ror1", 16'h8001, 4'd1, 1'b1, 2'b10, 16'h4000, 1'b1);
    run_op("rol3", 16'hA001, 4'd3, 1'b0, 2'b10, 16'h0008, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 16, the operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 4, the shift-amount width; the maximum amount is 2^CNT_W-1.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, the request strobe, sampled on the rising edge of clk.
REQ-006 SHALL have port operand, input, WIDTH, the value to shift, captured with start.
REQ-007 SHALL have port amount, input, CNT_W, the number of bit positions, captured with start.
REQ-008 SHALL have port right, input, 1, the direction: 1 = right, 0 = left.
REQ-009 SHALL have port mode, input, 2, the shift mode: 00 logical, 01 arithmetic, 10 rotate, 11 reserved.
REQ-010 SHALL have port busy, output, 1, high while an operation is in progress.
REQ-011 SHALL have port done, output, 1, a one-cycle pulse when the result is valid.
REQ-012 SHALL have port result, output, WIDTH, the shifted value.
REQ-013 SHALL have port carry, output, 1, the last bit shifted out.
REQ-014 SHALL have port zero, output, 1, high when result is all zero.

Function
REQ-015 SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-016 SHALL, in IDLE or DONE with start=1, capture operand, amount, right and mode, then go to SHIFT if amount!=0, otherwise to DONE.
REQ-017 SHALL perform exactly one 1-bit shift of the working register per cycle in SHIFT and decrement the counter; when the counter reaches 1, the next state is DONE.
REQ-018 SHALL produce a total latency of amount+1 cycles from the start edge to the done pulse, and 1 cycle for amount=0.
REQ-019 SHALL, for a logical right shift, fill the MSB with 0; for a left shift in any non-rotate mode, fill the LSB with 0.
REQ-020 SHALL, for an arithmetic right shift, replicate the MSB of the working register.
REQ-021 SHALL, for rotate, feed the bit shifted out back into the vacated end.
REQ-022 SHALL treat mode 11 as logical.
REQ-023 SHALL set carry to the bit shifted out on each step; for amount=0, carry SHALL be 0.
REQ-024 SHALL assert busy in SHIFT only, and assert done only on the cycle the FSM is in DONE.
REQ-025 SHALL pass from DONE to IDLE after one cycle, unless start=1, which begins a new operation directly.
REQ-026 SHALL ignore start while busy=1, leaving the captured parameters unchanged.
REQ-027 SHALL hold result, carry and zero stable from the done pulse until the next accepted start.
REQ-028 SHALL compute zero combinationally from result.

Reset
REQ-029 SHALL, on rst_n=0 and at any time including mid-SHIFT, immediately force the state to IDLE and drive busy=0, done=0, result=0, carry=0 and the counter to 0; zero SHALL then read 1.
REQ-030 SHALL, after rst_n is released, begin an operation only on the next start.

Configuration
REQ-031 SHALL, with SHIFT_SEQ_ROTATE_EN defined, implement mode 10 as rotate per REQ-021.
REQ-032 SHALL, without SHIFT_SEQ_ROTATE_EN, treat mode 10 as logical and contain no rotate feedback logic.

Structure
REQ-033 SHALL take the mode encodings (LOGIC, ARITH, ROTATE, RSVD) and the FSM state encodings from shared package alu_shift_pkg.
REQ-034 SHALL instantiate the single-step shift datapath as the sub-module shift_step, with inputs word, right and mode and outputs word and out_bit, used once per cycle.

Verification
REQ-035 SHALL cover: operand=16'h8001, amount=1, right=1, mode=00 -> done after 2 cycles, result=16'h4000, carry=1.
REQ-036 SHALL cover: operand=16'h8000, amount=4, right=1, mode=01 -> done after 5 cycles, result=16'hF800, carry=0.
REQ-037 SHALL cover: operand=16'h00F0, amount=0, right=0 -> done after 1 cycle, busy never high, result=16'h00F0, carry=0.
REQ-038 SHALL cover: operand=16'h0001, amount=15, right=0, mode=00 -> result=16'h8000 after 16 cycles; then amount=1 -> result=0, zero=1, carry=1.
REQ-039 SHALL cover: a second start at cycle 2 of an amount=8 operation -> ignored, and the first result completes unchanged.
REQ-040 SHALL cover: rst_n low mid-SHIFT -> busy=0, result=0, no done; then operand=16'h8001, amount=1, right=1, mode=10 -> result=16'hC000 with the macro, or 16'h4000 without it.
